// File: rtl/pipelined_barrel_rotator.sv
// Pipelined rotate/shift unit: log2(STEPS) mux stages, a register every STAGES_PER_REG stages,
// valid/ready handshake with full-rate back-pressure.
module pipelined_barrel_rotator #(
  parameter int DATAWIDTH          = 32,
  parameter int SHIFTBITS_PER_STEP = 1,
  parameter int STAGES_PER_REG     = 2
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic                                                inValid,
  output logic                                                inReady,
  input  logic [DATAWIDTH-1:0]                                inData,
  input  logic [$clog2(DATAWIDTH/SHIFTBITS_PER_STEP)-1:0]     inAmount,
  input  logic                                                inDirection,
  input  logic [1:0]                                          inMode,
  output logic                                                outValid,
  input  logic                                                outReady,
  output logic [DATAWIDTH-1:0]                                outData
);

  localparam int STEPS   = DATAWIDTH / SHIFTBITS_PER_STEP;
  localparam int NSTAGES = $clog2(STEPS);
  localparam int LATENCY = (NSTAGES + STAGES_PER_REG - 1) / STAGES_PER_REG;

  if (SHIFTBITS_PER_STEP < 1 || (DATAWIDTH % SHIFTBITS_PER_STEP) != 0 ||
      STEPS < 2 || (STEPS & (STEPS - 1)) != 0) begin : g_badWidth
    $error("DATAWIDTH/SHIFTBITS_PER_STEP must be a power of two >= 2");
  end
  if (STAGES_PER_REG < 1 || STAGES_PER_REG > NSTAGES) begin : g_badStages
    $error("STAGES_PER_REG must lie in 1..NSTAGES");
  end

  // One mux stage: move by sh bits when en is set; arithmetic right keeps the MSB, so chaining is exact.
  function automatic logic [DATAWIDTH-1:0] muxStage(input logic [DATAWIDTH-1:0] d,
                                                     input logic en,
                                                     input logic dirLeft,
                                                     input logic [1:0] mode,
                                                     input int sh);
    logic [DATAWIDTH-1:0] res;
    res = d;
    if (en) begin
      if (dirLeft) begin
        if (mode == 2'b01 || mode == 2'b10) res = d << sh;
        else                                res = (d << sh) | (d >> (DATAWIDTH - sh));
      end else begin
        case (mode)
          2'b01:   res = d >> sh;
          2'b10:   res = $signed(d) >>> sh;
          default: res = (d >> sh) | (d << (DATAWIDTH - sh));
        endcase
      end
    end
    return res;
  endfunction

  logic [LATENCY-1:0] r_valid;
  logic [LATENCY-1:0] w_load;

  // A stage may take new contents when it is empty or its successor is taking its current contents.
  always_comb begin
    w_load = '0;
    w_load[LATENCY-1] = !r_valid[LATENCY-1] || outReady;
    for (int j = LATENCY - 2; j >= 0; j--) begin
      w_load[j] = !r_valid[j] || w_load[j+1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
    end else begin
      if (w_load[0]) r_valid[0] <= inValid;
      for (int j = 1; j < LATENCY; j++) begin
        if (w_load[j]) r_valid[j] <= r_valid[j-1];
      end
    end
  end

  for (genvar j = 0; j < LATENCY; j++) begin : g_stage
    localparam int KLO = j * STAGES_PER_REG;
    localparam int KHI = ((j + 1) * STAGES_PER_REG > NSTAGES) ? NSTAGES : (j + 1) * STAGES_PER_REG;

    logic [DATAWIDTH-1:0] w_srcData;
    logic [DATAWIDTH-1:0] w_nextData;
    logic [NSTAGES-1:KLO] w_srcAmount;
    logic                 w_srcDir;
    logic [1:0]           w_srcMode;
    logic [DATAWIDTH-1:0] r_data;

    if (j == 0) begin : g_first
      assign w_srcData   = inData;
      assign w_srcAmount = inAmount;
      assign w_srcDir    = inDirection;
      assign w_srcMode   = inMode;
    end else begin : g_later
      assign w_srcData   = g_stage[j-1].r_data;
      assign w_srcAmount = g_stage[j-1].g_ctrl.r_amount;
      assign w_srcDir    = g_stage[j-1].g_ctrl.r_dir;
      assign w_srcMode   = g_stage[j-1].g_ctrl.r_mode;
    end

    always_comb begin
      w_nextData = w_srcData;
      for (int k = KLO; k < KHI; k++) begin
        w_nextData = muxStage(w_nextData, w_srcAmount[k], w_srcDir, w_srcMode,
                              (2 ** k) * SHIFTBITS_PER_STEP);
      end
    end

    always_ff @(posedge clk) begin
      if (reset)          r_data <= '0;
      else if (w_load[j]) r_data <= w_nextData;
    end

    // Only the amount bits still to be consumed travel on to later stages.
    if (j < LATENCY - 1) begin : g_ctrl
      logic [NSTAGES-1:KHI] r_amount;
      logic                 r_dir;
      logic [1:0]           r_mode;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_amount <= '0;
          r_dir    <= 1'b0;
          r_mode   <= 2'b00;
        end else if (w_load[j]) begin
          r_amount <= w_srcAmount[NSTAGES-1:KHI];
          r_dir    <= w_srcDir;
          r_mode   <= w_srcMode;
        end
      end
    end
  end

  assign inReady  = w_load[0] && !reset;
  assign outValid = r_valid[LATENCY-1];
  assign outData  = g_stage[LATENCY-1].r_data;

endmodule

// File: tb/tb_pipelined_barrel_rotator.sv
// Directed checks of pipelined_barrel_rotator: default config (latency 3) plus a byte rotator
// (S=8, one stage per register, latency 2), with a short random back-pressure run.
module tb_pipelined_barrel_rotator;

  logic        clk;
  logic        reset;
  logic        inValid, inReady, inDirection, outValid, outReady;
  logic [31:0] inData, outData;
  logic [4:0]  inAmount;
  logic [1:0]  inMode;

  logic        inValid1, inReady1, inDirection1, outValid1, outReady1;
  logic [31:0] inData1, outData1;
  logic [1:0]  inAmount1;
  logic [1:0]  inMode1;

  int total = 0;
  int bad   = 0;

  pipelined_barrel_rotator #(.DATAWIDTH(32), .SHIFTBITS_PER_STEP(1), .STAGES_PER_REG(2)) dut0 (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady), .inData(inData),
    .inAmount(inAmount), .inDirection(inDirection), .inMode(inMode),
    .outValid(outValid), .outReady(outReady), .outData(outData));

  pipelined_barrel_rotator #(.DATAWIDTH(32), .SHIFTBITS_PER_STEP(8), .STAGES_PER_REG(1)) dut1 (
    .clk(clk), .reset(reset), .inValid(inValid1), .inReady(inReady1), .inData(inData1),
    .inAmount(inAmount1), .inDirection(inDirection1), .inMode(inMode1),
    .outValid(outValid1), .outReady(outReady1), .outData(outData1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Bit-index reference for the default 1-bit-step configuration.
  function automatic logic [31:0] refModel(input logic [31:0] d, input int n, input logic left,
                                           input logic [1:0] mode);
    logic [31:0] r;
    int src;
    for (int i = 0; i < 32; i++) begin
      if (!left) begin
        src = i + n;
        if (src < 32)           r[i] = d[src];
        else if (mode == 2'b01) r[i] = 1'b0;
        else if (mode == 2'b10) r[i] = d[31];
        else                    r[i] = d[src-32];
      end else begin
        src = i - n;
        if (src >= 0)                           r[i] = d[src];
        else if (mode == 2'b01 || mode == 2'b10) r[i] = 1'b0;
        else                                    r[i] = d[src+32];
      end
    end
    return r;
  endfunction

  // Sends one beat to dut0 (sel=0) or dut1 (sel=1) and checks its latency and result.
  task automatic applyStimulus(input bit sel, input logic [31:0] data, input int amt, input logic dir,
                               input logic [1:0] mode, input logic [31:0] expected, input int expLat,
                               input string tag);
    int lat;
    bit seen;
    @(posedge clk); #1;
    if (!sel) begin
      inValid = 1'b1; inData = data; inAmount = amt[4:0]; inDirection = dir; inMode = mode; outReady = 1'b1;
    end else begin
      inValid1 = 1'b1; inData1 = data; inAmount1 = amt[1:0]; inDirection1 = dir; inMode1 = mode; outReady1 = 1'b1;
    end
    @(negedge clk);
    checkOutput({tag, "_rdy"}, 32'(sel ? inReady1 : inReady), 32'd1);
    @(posedge clk); #1;
    inValid  = 1'b0;
    inValid1 = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 10) begin
      @(negedge clk);
      lat++;
      if (sel ? outValid1 : outValid) seen = 1'b1;
    end
    checkOutput({tag, "_lat"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_data"}, sel ? outData1 : outData, expected);
    @(posedge clk);
  endtask

  initial begin
    int sent, got, lastCyc, highs;
    logic [31:0] q[$];
    logic [31:0] holdData;
    bit prevStall;

    reset = 1'b1;
    inValid = 0; inData = 0; inAmount = 0; inDirection = 0; inMode = 0; outReady = 1;
    inValid1 = 0; inData1 = 0; inAmount1 = 0; inDirection1 = 0; inMode1 = 0; outReady1 = 1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_outValid", 32'(outValid), 32'd0);
    checkOutput("rst_outData", outData, 32'd0);
    checkOutput("rst_inReady", 32'(inReady), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_inReady", 32'(inReady), 32'd1);
    checkOutput("post_rst_outValid", 32'(outValid), 32'd0);

    // Basic rotates, including reserved mode 11
    applyStimulus(0, 32'h80000001, 1, 1'b0, 2'b00, 32'hC0000000, 3, "rotr1");
    applyStimulus(0, 32'h80000001, 4, 1'b1, 2'b00, 32'h00000018, 3, "rotl4");
    applyStimulus(0, 32'h80000001, 1, 1'b0, 2'b11, 32'hC0000000, 3, "rotr1_m3");
    applyStimulus(0, 32'h80000001, 4, 1'b1, 2'b11, 32'h00000018, 3, "rotl4_m3");
    applyStimulus(0, 32'h12345678, 8, 1'b1, 2'b00, 32'h34567812, 3, "rotl8");
    applyStimulus(0, 32'h12345678, 12, 1'b0, 2'b00, 32'h67812345, 3, "rotr12");

    // Shifts and boundaries
    applyStimulus(0, 32'h80000000, 31, 1'b0, 2'b10, 32'hFFFFFFFF, 3, "asr31");
    applyStimulus(0, 32'h80000000, 31, 1'b0, 2'b01, 32'h00000001, 3, "lsr31");
    applyStimulus(0, 32'h0000FFFF, 8, 1'b1, 2'b01, 32'h00FFFF00, 3, "lsl8");
    applyStimulus(0, 32'h40000000, 2, 1'b0, 2'b10, 32'h10000000, 3, "asr_pos");
    applyStimulus(0, 32'h80000001, 4, 1'b1, 2'b10, 32'h00000010, 3, "asl4");
    applyStimulus(0, 32'h80000000, 0, 1'b0, 2'b10, 32'h80000000, 3, "amt0_asr");
    applyStimulus(0, 32'hDEADBEEF, 0, 1'b1, 2'b00, 32'hDEADBEEF, 3, "amt0_rotl");

    // Ten back-to-back beats, output stalled during cycles 4..7
    sent = 0; got = 0; lastCyc = 0;
    for (int cyc = 1; cyc <= 40 && got < 10; cyc++) begin
      @(posedge clk); #1;
      inValid = (sent < 10); inData = 32'(sent); inAmount = 5'd1; inDirection = 1'b1; inMode = 2'b00;
      outReady = !(cyc >= 4 && cyc <= 7);
      @(negedge clk);
      if (cyc == 3) checkOutput("stream_rdy_c3", 32'(inReady), 32'd1);
      if (cyc == 4 || cyc == 7) checkOutput("stream_rdy_stall", 32'(inReady), 32'd0);
      if (cyc == 8) checkOutput("stream_rdy_c8", 32'(inReady), 32'd1);
      if (cyc >= 4 && cyc <= 7) begin
        checkOutput("stall_valid", 32'(outValid), 32'd1);
        checkOutput("stall_data", outData, 32'd0);
      end
      if (inValid && inReady) sent++;
      if (outValid && outReady) begin
        checkOutput("stream_order", outData, 32'(2 * got));
        got++;
        if (got == 10) lastCyc = cyc;
      end
    end
    inValid = 1'b0;
    checkOutput("stream_count", 32'(got), 32'd10);
    checkOutput("stream_cycles", 32'(lastCyc - 1), 32'd16);

    // Reset with a full pipeline
    @(posedge clk); #1;
    outReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      inValid = 1'b1; inData = 32'hA0 + 32'(i); inAmount = 5'd1; inDirection = 1'b0; inMode = 2'b00;
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_full", 32'(outValid), 32'd1);
    checkOutput("midrst_inReady", 32'(inReady), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    outReady = 1'b1;
    @(negedge clk);
    checkOutput("midrst_outValid", 32'(outValid), 32'd0);
    checkOutput("midrst_outData", outData, 32'd0);
    checkOutput("midrst_rdy", 32'(inReady), 32'd1);
    highs = 0;
    repeat (6) begin
      @(negedge clk);
      if (outValid) highs++;
    end
    checkOutput("midrst_no_ghost", 32'(highs), 32'd0);
    applyStimulus(0, 32'h0000F00F, 4, 1'b0, 2'b00, 32'hF0000F00, 3, "after_rst");

    // Random traffic with back-pressure against the bit-index model
    sent = 0; got = 0; prevStall = 1'b0; holdData = '0;
    for (int cyc = 0; cyc < 4000 && got < 300; cyc++) begin
      @(posedge clk); #1;
      inValid     = (sent < 300) && ($urandom_range(0, 3) != 0);
      inData      = $urandom;
      inAmount    = 5'($urandom_range(0, 31));
      inDirection = 1'($urandom_range(0, 1));
      inMode      = 2'($urandom_range(0, 3));
      outReady    = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (prevStall) begin
        checkOutput("rnd_hold_valid", 32'(outValid), 32'd1);
        checkOutput("rnd_hold_data", outData, holdData);
      end
      prevStall = outValid && !outReady;
      holdData  = outData;
      if (inValid && inReady) begin
        q.push_back(refModel(inData, int'(inAmount), inDirection, inMode));
        sent++;
      end
      if (outValid && outReady) begin
        if (q.size() == 0) checkOutput("rnd_extra", 32'd1, 32'd0);
        else               checkOutput("rnd_data", outData, q.pop_front());
        got++;
      end
    end
    inValid = 1'b0;
    outReady = 1'b1;
    checkOutput("rnd_count", 32'(got), 32'd300);

    // Byte rotator
    applyStimulus(1, 32'h11223344, 1, 1'b0, 2'b00, 32'h44112233, 2, "byte_rotr1");
    applyStimulus(1, 32'h80112233, 3, 1'b0, 2'b10, 32'hFFFFFF80, 2, "byte_asr3");
    applyStimulus(1, 32'h11223344, 2, 1'b1, 2'b01, 32'h33440000, 2, "byte_lsl2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
